// File: rtl/apb_requester.sv
// APB3 requester: turns a valid/ready command into one APB transfer and
// reports read data or a watchdog abort on a single-cycle response strobe.
module apb_requester #(
   parameter int AW      = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 16
) (
   input  logic          pclk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          psel,
   output logic          penable,
   output logic [AW-1:0] paddr,
   output logic          pwrite,
   output logic [DW-1:0] pwdata,
   input  logic [DW-1:0] prdata,
   input  logic          pready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t     state_r;
   logic [7:0] wait_cnt_r;

   // Ready only in IDLE, and forced low while reset is held.
   assign cmd_ready = rst_n && (state_r == IDLE);

   // Transfer sequencer with registered APB and response outputs.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         wait_cnt_r <= 8'd0;
         psel       <= 1'b0;
         penable    <= 1'b0;
         paddr      <= {AW{1'b0}};
         pwrite     <= 1'b0;
         pwdata     <= {DW{1'b0}};
         rsp_valid  <= 1'b0;
         rsp_rdata  <= {DW{1'b0}};
         rsp_err    <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               penable <= 1'b0;
               if (cmd_valid) begin
                  paddr      <= cmd_addr;
                  pwrite     <= cmd_write;
                  pwdata     <= cmd_wdata;
                  psel       <= 1'b1;
                  wait_cnt_r <= 8'd0;
                  state_r    <= SETUP;
               end else begin
                  psel <= 1'b0;
               end
            end
            SETUP: begin
               psel    <= 1'b1;
               penable <= 1'b1;
               state_r <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= pwrite ? {DW{1'b0}} : prdata;
                  state_r   <= IDLE;
               end else if ((TIMEOUT_C != 8'd0) && (wait_cnt_r == TIMEOUT_C - 8'd1)) begin
                  // This low edge is the TIMEOUT-th one: give up on the slave.
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= {DW{1'b0}};
                  state_r   <= IDLE;
               end else if (wait_cnt_r != 8'hFF) begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end else begin
                  wait_cnt_r <= wait_cnt_r;
               end
            end
            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
